hc00_test_ctrl: RTL
===================

HC00_TEST_CTRL -- requirements
Module: hc00_test_ctrl

Interface
REQ-001 Parameter NUM_GATES, default 4, number of 2-input NAND gates under test (1..4).
REQ-002 Parameter SETTLE_CYC, default 4, clock cycles a vector is held before sampling (3..255).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to run a full test sequence.
REQ-007 abort  input  1  terminates a running sequence.
REQ-008 y_i  input  NUM_GATES  gate outputs returned from the device under test; asynchronous to clk.
REQ-009 a_o  output  NUM_GATES  A input driven to every gate.
REQ-010 b_o  output  NUM_GATES  B input driven to every gate.
REQ-011 busy  output  1  high while a sequence runs.
REQ-012 done  output  1  one-cycle pulse on normal completion.
REQ-013 pass  output  1  last completed sequence had no mismatches.
REQ-014 fail_mask  output  NUM_GATES  bit n set if gate n mismatched on any vector.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, SAMPLE, FIN.
REQ-016 y_i SHALL pass through a two-flop synchronizer before comparison; its latency is covered by SETTLE_CYC.
REQ-017 IDLE: a_o=b_o=0, busy=0; start=1 and abort=0 -> SETTLE, vector index v=0, fail_mask cleared, pass cleared, settle counter loaded with SETTLE_CYC-1.
REQ-018 Vector v (2 bits) SHALL drive a_o = all bits v[1], b_o = all bits v[0]; order 00,01,10,11.
REQ-019 SETTLE: counter decrements each cycle; at 0 -> SAMPLE.
REQ-020 SAMPLE: expected = ~(a_o & b_o) per gate; fail_mask |= synced_y ^ expected; v=3 -> FIN, else v+1, counter reloaded, -> SETTLE.
REQ-021 Each vector SHALL take SETTLE_CYC+1 cycles; busy high for exactly 4*(SETTLE_CYC+1) cycles, starting the cycle after start is sampled.
REQ-022 FIN: done=1 for one cycle, pass = (fail_mask==0) including the final SAMPLE's update, a_o=b_o=0, -> IDLE.
REQ-023 pass and fail_mask SHALL hold their values in IDLE until the next accepted start.
REQ-024 start while busy or in FIN SHALL be ignored.
REQ-025 abort in SETTLE or SAMPLE SHALL go to IDLE next cycle, no done pulse, pass=0, fail_mask keeps partial result.
REQ-026 abort and start together in IDLE: abort wins, no sequence starts.
REQ-027 Gates at or above NUM_GATES do not exist; no unused widths.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, a_o=0, b_o=0, busy=0, done=0, pass=0, fail_mask=0, v=0, counter=0, synchronizer flops=0.
REQ-029 rst SHALL take priority over start and abort, including mid-sequence; no done pulse results.

Structure
REQ-030 Package hc00_test_pkg SHALL hold the state enum, vector count constant (4), and the NAND expected-value function.
REQ-031 The synchronizer SHALL be sub-module hc00_sync2, parameterized on width.
REQ-032 The FSM, counter and comparison SHALL live in hc00_test_ctrl; RTL 120-400 lines total.

Verification
REQ-033 Ideal NAND model on y_i, SETTLE_CYC=4, start pulse -> busy 20 cycles, done one cycle later, pass=1, fail_mask=0000.
REQ-034 Gate 2 stuck at 1 -> fail on vector 11 only; done, pass=0, fail_mask=0100.
REQ-035 Gate 0 stuck at 0 -> fail_mask=0001, pass=0; following run with good model -> pass=1, fail_mask=0000.
REQ-036 abort on 7th busy cycle -> busy low next cycle, no done, pass=0; a_o=b_o=0.
REQ-037 start repeated during busy -> exactly one done per accepted start; rst on busy cycle 10 -> all outputs 0 next cycle, no done.
REQ-038 SETTLE_CYC=3, NUM_GATES=1 -> busy 16 cycles, sampled value equals the vector driven 3 cycles earlier.

Source files
------------

// File: rtl/hc00_test_pkg.sv
// Shared types and helpers for the 2-input NAND gate tester.
package hc00_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FIN
  } state_t;

  // Test vectors are applied in the order 00, 01, 10, 11.
  localparam int NUM_VEC = 4;

  // Output expected from an ideal NAND gate.
  function automatic logic nand_exp(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/hc00_test_ctrl_if.sv
// Control and gate-stimulus bundle between a test host and hc00_test_ctrl.
interface hc00_test_ctrl_if #(
  parameter int NUM_GATES = 4
);
  logic                 start;
  logic                 abort;
  logic [NUM_GATES-1:0] y_i;
  logic [NUM_GATES-1:0] a_o;
  logic [NUM_GATES-1:0] b_o;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_GATES-1:0] fail_mask;

  modport master (
    output start, abort, y_i,
    input  a_o, b_o, busy, done, pass, fail_mask
  );

  modport slave (
    input  start, abort, y_i,
    output a_o, b_o, busy, done, pass, fail_mask
  );
endinterface

// File: rtl/hc00_sync2.sv
// Two-flop synchronizer for the gate outputs, which arrive asynchronously to clk.
module hc00_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture; both flops clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/hc00_test_ctrl.sv
// Walks four A/B vectors across up to four NAND gates, lets each vector settle
// for SETTLE_CYC cycles, then compares the synchronized gate outputs.
module hc00_test_ctrl
  import hc00_test_pkg::*;
#(
  parameter int NUM_GATES  = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  hc00_test_ctrl_if.slave  bus
);
  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYC - 1);
  localparam logic [1:0] V_LAST     = 2'(NUM_VEC - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_cnt;
  logic [1:0]           r_v;
  logic [NUM_GATES-1:0] r_fail_mask;
  logic                 r_pass;
  logic [NUM_GATES-1:0] w_sync_y;
  logic [NUM_GATES-1:0] w_exp;
  logic [NUM_GATES-1:0] w_fail_nxt;
  logic                 w_run;
  logic                 w_accept;

  hc00_sync2 #(.WIDTH(NUM_GATES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.y_i),
    .o_q (w_sync_y)
  );

  assign w_run      = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign w_accept   = bus.start && !bus.abort;
  // Every gate sees the same A/B pair, so one expected bit is replicated.
  assign w_exp      = {NUM_GATES{nand_exp(r_v[1], r_v[0])}};
  assign w_fail_nxt = r_fail_mask | (w_sync_y ^ w_exp);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; abort wins over start and over sampling.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (bus.abort)        w_state_nxt = ST_IDLE;
        else if (r_cnt == '0) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (bus.abort)         w_state_nxt = ST_IDLE;
        else if (r_v == V_LAST) w_state_nxt = ST_FIN;
        else                   w_state_nxt = ST_SETTLE;
      end
      ST_FIN:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Vector index, settle counter and result registers. An aborted SAMPLE
  // cycle does not fold its comparison into the mask. Pass is resolved on the
  // last SAMPLE edge so it is already valid alongside the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_v         <= '0;
      r_fail_mask <= '0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_v         <= '0;
            r_cnt       <= CNT_RELOAD;
            r_fail_mask <= '0;
            r_pass      <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (bus.abort)        r_pass <= 1'b0;
          else if (r_cnt != '0) r_cnt  <= r_cnt - 8'd1;
        end
        ST_SAMPLE: begin
          if (bus.abort) begin
            r_pass <= 1'b0;
          end else begin
            r_fail_mask <= w_fail_nxt;
            if (r_v == V_LAST) begin
              r_pass <= (w_fail_nxt == '0);
            end else begin
              r_v   <= r_v + 2'd1;
              r_cnt <= CNT_RELOAD;
            end
          end
        end
        ST_FIN:  r_v <= '0;
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_run;
  assign bus.done      = (r_state == ST_FIN);
  assign bus.a_o       = w_run ? {NUM_GATES{r_v[1]}} : '0;
  assign bus.b_o       = w_run ? {NUM_GATES{r_v[0]}} : '0;
  assign bus.pass      = r_pass;
  assign bus.fail_mask = r_fail_mask;
endmodule
